// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RISC-V M-extension multiply/divide unit.
// W-bit operands, one bit per cycle: radix-2 shift-add multiply and
// restoring divide. Valid/ready on both sides, synchronous kill for flushes.
// Optional build macro MULDIV_ITER_EARLY_EXIT_EN: a multiply leaves CALC as
// soon as the remaining multiplier bits are all zero. It does this by
// barrel-shifting the accumulator by the number of steps still pending.
module muldiv_iter #(
   parameter int W = 32
) (
   input  logic         s_clk_i,
   input  logic         s_resetn_i,
   input  logic         s_valid_i,
   output logic         s_ready_o,
   input  logic [2:0]   s_function_i,
   input  logic [W-1:0] s_operand1_i,
   input  logic [W-1:0] s_operand2_i,
   input  logic         s_kill_i,
   output logic         s_valid_o,
   input  logic         s_ready_i,
   output logic [W-1:0] s_result_o
);

   localparam int CW = $clog2(W + 1);

   localparam logic [W-1:0]    ZERO_W  = {W{1'b0}};
   localparam logic [W-1:0]    ONES_W  = {W{1'b1}};
   localparam logic [W-1:0]    MIN_W   = {1'b1, {(W-1){1'b0}}};
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [CW-1:0]   CNT_W   = CW'(W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // two's complement of a W-bit value
   function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
      return ~v + {{(W-1){1'b0}}, 1'b1};
   endfunction

   // two's complement of a 2W-bit value
   function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
      return ~v + {{(2*W-1){1'b0}}, 1'b1};
   endfunction

   state_t          state_r;
   logic [2:0]      func_r;
   logic            neg_r;
   logic [W-1:0]    opa_r;     // multiplicand magnitude
   logic [W-1:0]    opb_r;     // multiplier (shifts right) or divisor magnitude
   logic [2*W:0]    acc_r;     // product accumulator / {partial remainder, quotient}
   logic [CW-1:0]   cnt_r;
   logic            valid_r;
   logic [W-1:0]    result_r;

   logic            signed1_s;
   logic            signed2_s;
   logic            sign1_s;
   logic            sign2_s;
   logic [W-1:0]    mag1_s;
   logic [W-1:0]    mag2_s;
   logic            neg_s;
   logic            direct_s;
   logic [W-1:0]    direct_val_s;

   logic [W:0]      mul_sum_s;
   logic [2*W:0]    mul_next_s;
   logic [W+1:0]    div_diff_s;
   logic            div_borrow_s;
   logic [2*W:0]    div_next_s;
   logic [2*W-1:0]  prod_s;
   logic [W-1:0]    quo_rem_s;
   logic [W-1:0]    fix_val_s;

   assign s_ready_o  = (state_r == ST_IDLE);
   assign s_valid_o  = valid_r;
   assign s_result_o = result_r;

   // request decode: operand signedness, magnitudes, negate flag, direct results
   always_comb begin
      signed1_s    = 1'b0;
      signed2_s    = 1'b0;
      neg_s        = 1'b0;
      direct_s     = 1'b0;
      direct_val_s = ZERO_W;
      case (s_function_i)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            signed1_s = 1'b1;
            signed2_s = 1'b1;
         end
         3'b010: begin
            signed1_s = 1'b1;
            signed2_s = 1'b0;
         end
         default: begin
            signed1_s = 1'b0;
            signed2_s = 1'b0;
         end
      endcase
      sign1_s = signed1_s & s_operand1_i[W-1];
      sign2_s = signed2_s & s_operand2_i[W-1];
      mag1_s  = sign1_s ? neg_w(s_operand1_i) : s_operand1_i;
      mag2_s  = sign2_s ? neg_w(s_operand2_i) : s_operand2_i;
      // remainder takes the dividend's sign, everything else the XOR
      if (s_function_i[2] && s_function_i[1]) begin
         neg_s = sign1_s;
      end else begin
         neg_s = sign1_s ^ sign2_s;
      end
      if (s_function_i[2] && (s_operand2_i == ZERO_W)) begin
         direct_s     = 1'b1;
         direct_val_s = s_function_i[1] ? s_operand1_i : ONES_W;
      end else if (s_function_i[2] && !s_function_i[0] &&
                   (s_operand1_i == MIN_W) && (s_operand2_i == ONES_W)) begin
         direct_s     = 1'b1;
         direct_val_s = s_function_i[1] ? ZERO_W : s_operand1_i;
      end else if (s_operand1_i == ZERO_W) begin
         direct_s     = 1'b1;
         direct_val_s = ZERO_W;
      end else begin
         direct_s     = 1'b0;
         direct_val_s = ZERO_W;
      end
   end

   // one iteration step of the shift-add multiplier and the restoring divider
   always_comb begin
      mul_sum_s    = acc_r[2*W:W] + {1'b0, (opb_r[0] ? opa_r : ZERO_W)};
      mul_next_s   = {1'b0, mul_sum_s, acc_r[W-1:1]};
      div_diff_s   = {1'b0, acc_r[2*W-1:W-1]} - {2'b00, opb_r};
      div_borrow_s = div_diff_s[W+1];
      if (div_borrow_s) begin
         div_next_s = {1'b0, acc_r[2*W-2:0], 1'b0};
      end else begin
         div_next_s = {1'b0, div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
      end
   end

   // final sign fix-up and half/quotient/remainder selection
   always_comb begin
      prod_s    = neg_r ? neg_2w(acc_r[2*W-1:0]) : acc_r[2*W-1:0];
      quo_rem_s = func_r[1] ? acc_r[2*W-1:W] : acc_r[W-1:0];
      if (func_r[2]) begin
         fix_val_s = neg_r ? neg_w(quo_rem_s) : quo_rem_s;
      end else if (func_r[1:0] != 2'b00) begin
         fix_val_s = prod_s[2*W-1:W];
      end else begin
         fix_val_s = prod_s[W-1:0];
      end
   end

   // control FSM with datapath registers and registered outputs
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_r  <= ST_IDLE;
         func_r   <= 3'b000;
         neg_r    <= 1'b0;
         opa_r    <= ZERO_W;
         opb_r    <= ZERO_W;
         acc_r    <= {(2*W+1){1'b0}};
         cnt_r    <= {CW{1'b0}};
         valid_r  <= 1'b0;
         result_r <= ZERO_W;
      end else if (s_kill_i) begin
         state_r  <= ST_IDLE;
         valid_r  <= 1'b0;
         result_r <= ZERO_W;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (s_valid_i) begin
                  func_r <= s_function_i;
                  neg_r  <= neg_s;
                  opa_r  <= mag1_s;
                  opb_r  <= mag2_s;
                  cnt_r  <= CNT_W;
                  // divide starts with the dividend in the quotient half
                  acc_r  <= s_function_i[2] ? {{(W+1){1'b0}}, mag1_s}
                                            : {(2*W+1){1'b0}};
                  if (direct_s) begin
                     result_r <= direct_val_s;
                     valid_r  <= 1'b1;
                     state_r  <= ST_DONE;
                  end else begin
                     state_r  <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (func_r[2]) begin
                  acc_r <= div_next_s;
                  cnt_r <= cnt_r - CNT_ONE;
                  if (cnt_r == CNT_ONE) begin
                     state_r <= ST_FIX;
                  end
               end
`ifdef MULDIV_ITER_EARLY_EXIT_EN
               else if (opb_r == ZERO_W) begin
                  // remaining steps would only shift: do them all at once
                  acc_r   <= acc_r >> cnt_r;
                  cnt_r   <= {CW{1'b0}};
                  state_r <= ST_FIX;
               end
`endif
               else begin
                  acc_r <= mul_next_s;
                  opb_r <= opb_r >> 1;
                  cnt_r <= cnt_r - CNT_ONE;
                  if (cnt_r == CNT_ONE) begin
                     state_r <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               result_r <= fix_val_s;
               valid_r  <= 1'b1;
               state_r  <= ST_DONE;
            end
            ST_DONE: begin
               if (s_ready_i) begin
                  valid_r <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter (W=32): directed corner cases, kill, backpressure,
// reset mid-operation, then randomized requests checked against an
// arithmetic reference model. Honours MULDIV_ITER_EARLY_EXIT_EN for latency.
module tb_muldiv_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   func = 3'b000;
   logic [W-1:0] op1 = 32'h0;
   logic [W-1:0] op2 = 32'h0;
   logic         kill = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_iter #(.W(W)) dut (
      .s_clk_i      (clk),
      .s_resetn_i   (rst_n),
      .s_valid_i    (in_valid),
      .s_ready_o    (in_ready),
      .s_function_i (func),
      .s_operand1_i (op1),
      .s_operand2_i (op2),
      .s_kill_i     (kill),
      .s_valid_o    (out_valid),
      .s_ready_i    (out_ready),
      .s_result_o   (result)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference: RISC-V M-extension semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   // cycles from the accept edge to the edge after which s_valid_o is high
   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int h;
      if (f[2] && b == 32'h0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      if (a == 32'h0) return 1;
      if (f[2]) return W + 1;
`ifdef MULDIV_ITER_EARLY_EXIT_EN
      if (b == 32'h0) return 2;
      h = 0;
      for (int i = 0; i < W; i++) if (b[i]) h = i;
      return (h + 3 < W + 1) ? h + 3 : W + 1;
`else
      h = 0;
      return W + 1 + h;
`endif
   endfunction

   function automatic logic [31:0] pick_operand();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4, 5: return 32'($urandom_range(1, 300));
         6: return 32'(-$signed(32'($urandom_range(1, 300))));
         default: return $urandom;
      endcase
   endfunction

   // issue one request, check latency, busy flag, result under hold cycles, handshake
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
      int lat;
      lat = 0;
      @(negedge clk);
      check_eq("ready_idle", 32'(in_ready), 32'd1);
      func = f; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      func = 3'($urandom); op1 = $urandom; op2 = $urandom;
      check_eq("busy", 32'(in_ready), 32'd0);
      for (int n = 1; n <= W + 8; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      check_eq($sformatf("lat f=%0d a=%h b=%h", f, a, b), 32'(lat), 32'(exp_lat(f, a, b)));
      check_eq($sformatf("res f=%0d a=%h b=%h", f, a, b), result, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_result", result, exp);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("post_valid", 32'(out_valid), 32'd0);
      check_eq("post_ready", 32'(in_ready), 32'd1);
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   vec_t dir[$];

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      dir.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
      dir.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
      dir.push_back('{3'd5, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF});
      dir.push_back('{3'd7, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007});
      dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
      dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
      dir.push_back('{3'd3, 32'h0000_0005, 32'h0000_0001, 32'h0000_0000});
      dir.push_back('{3'd0, 32'h0000_0005, 32'h0000_0001, 32'h0000_0005});
      dir.push_back('{3'd1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000});
      dir.push_back('{3'd7, 32'hFFFF_FFF9, 32'h0000_0010, 32'h0000_0009});

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_result", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (dir[i]) do_op(dir[i].f, dir[i].a, dir[i].b, dir[i].r, 0);

      // kill ten cycles into a multiply
      @(negedge clk);
      func = 3'd0; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         check_eq("kill_pre_valid", 32'(out_valid), 32'd0);
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check_eq("kill_valid", 32'(out_valid), 32'd0);
      check_eq("kill_ready", 32'(in_ready), 32'd1);
      repeat (W + 4) begin
         @(posedge clk); #1;
         check_eq("kill_quiet", 32'(out_valid), 32'd0);
      end
      do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);

      // backpressure: result held for five cycles
      do_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, ref_calc(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D), 5);

      // asynchronous reset mid-CALC clears a nonzero held result
      do_op(3'd0, 32'd3, 32'd5, 32'd15, 0);
      @(negedge clk);
      func = 3'd0; op1 = 32'h0000_1111; op2 = 32'h8000_0003; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_result", result, 32'h0);
      check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized requests against the reference model
      for (int k = 0; k < 250; k++) begin
         f = 3'($urandom_range(0, 7));
         a = pick_operand();
         b = pick_operand();
         do_op(f, a, b, ref_calc(f, a, b), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
